jtag_tap_sequencer: RTL and testbench

//  Bit-bang JTAG master driving TCK/TMS/TDI and sampling TDO on the board's 8-way JTAG header.

---
 rtl/jtag_tap_sequencer_if.sv | 41 ++++
 rtl/jtag_tap_sequencer.sv | 206 ++++++++++++++++++++
 tb/tb_jtag_tap_sequencer.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/jtag_tap_sequencer_if.sv
// rtl/jtag_tap_sequencer_if.sv - command/response bundle between a host and jtag_tap_sequencer
// Macro: JTAG_TDO_CMP_EN adds cmd_exp/cmd_mask (host->sequencer) and rsp_mismatch (sequencer->host).
// Signals: cmd_valid/cmd_ready/cmd_op/cmd_len/cmd_tdi command handshake;
//          rsp_valid/rsp_tdo response; busy = ~cmd_ready.
// Modports: master = host side, slave = sequencer side.
interface jtag_tap_sequencer_if #(
    parameter int DATA_W = 32,
    parameter int LEN_W  = 6
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_op;
    logic [LEN_W-1:0]  cmd_len;
    logic [DATA_W-1:0] cmd_tdi;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_tdo;
    logic              busy;
`ifdef JTAG_TDO_CMP_EN
    logic [DATA_W-1:0] cmd_exp;
    logic [DATA_W-1:0] cmd_mask;
    logic              rsp_mismatch;
`endif

    modport master (
        output cmd_valid, cmd_op, cmd_len, cmd_tdi,
`ifdef JTAG_TDO_CMP_EN
        output cmd_exp, cmd_mask,
        input  rsp_mismatch,
`endif
        input  cmd_ready, rsp_valid, rsp_tdo, busy
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_len, cmd_tdi,
`ifdef JTAG_TDO_CMP_EN
        input  cmd_exp, cmd_mask,
        output rsp_mismatch,
`endif
        output cmd_ready, rsp_valid, rsp_tdo, busy
    );
endinterface

// File: rtl/jtag_tap_sequencer.sv
// rtl/jtag_tap_sequencer.sv - bit-bang JTAG master: TAP reset, IR/DR shift and RTI idle clocking
// Macro: JTAG_TDO_CMP_EN enables the masked TDO compare (rsp_mismatch).
// Ports: clk, reset (async, active-high); bus (jtag_tap_sequencer_if.slave) carries the
//        command/response handshake; TCK/TMS/TDI drive the target, TDO is sampled from it.
// The TAP parks in Run-Test/Idle between commands.
module jtag_tap_sequencer #(
    parameter int CLKDIV = 4,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 6
) (
    input  logic                   clk,
    input  logic                   reset,
    jtag_tap_sequencer_if.slave    bus,
    output logic                   TCK,
    output logic                   TMS,
    output logic                   TDI,
    input  logic                   TDO
);
    localparam int DIV_W = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
    localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [1:0] OP_RESET = 2'b00;
    localparam logic [1:0] OP_IR    = 2'b01;
    localparam logic [1:0] OP_DR    = 2'b10;
    localparam logic [1:0] OP_IDLE  = 2'b11;

    typedef enum logic [2:0] {S_IDLE, S_TLR, S_PRE, S_SHIFT, S_POST, S_RUN, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [LEN_W-1:0]  cnt_q, cnt_d, n_q, n_d, len_eff;
    logic [1:0]        op_q, op_d;
    logic [DATA_W-1:0] tdi_q, tdi_d, rsp_tdo_q, rsp_tdo_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic              tck_q, tck_d, tms_q, tms_d, tdo_pin_q, tdo_pin_d;
    logic              synced_q, synced_d, rsp_valid_q, rsp_valid_d;
    logic              accept, new_period, cmd_is_shift;

    // Every non-reset command enters the TAP from RTI; only the entry path differs.
    function automatic state_t first_state(input logic [1:0] op);
        return (op == OP_IDLE) ? S_RUN : S_PRE;
    endfunction

    assign accept       = bus.cmd_valid && (state_q == S_IDLE);
    assign cmd_is_shift = (bus.cmd_op == OP_IR) || (bus.cmd_op == OP_DR);
    assign len_eff      = (cmd_is_shift && bus.cmd_len > LEN_W'(DATA_W)) ? LEN_W'(DATA_W) : bus.cmd_len;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        n_d         = n_q;
        op_d        = op_q;
        tdi_d       = tdi_q;
        rsp_tdo_d   = rsp_tdo_q;
        div_d       = div_q;
        tck_d       = tck_q;
        tms_d       = tms_q;
        tdo_pin_d   = tdo_pin_q;
        synced_d    = synced_q;
        rsp_valid_d = 1'b0;
        new_period  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    op_d       = bus.cmd_op;
                    n_d        = len_eff;
                    tdi_d      = bus.cmd_tdi;
                    rsp_tdo_d  = '0;
                    cnt_d      = '0;
                    div_d      = '0;
                    tck_d      = 1'b0;
                    new_period = 1'b1;
                    // Zero-length work produces no TCK activity at all, synced or not.
                    if (bus.cmd_op != OP_RESET && len_eff == '0) begin
                        rsp_valid_d = 1'b1;
                    end else if (!synced_q || bus.cmd_op == OP_RESET) begin
                        state_d = S_TLR;
                    end else begin
                        state_d = first_state(bus.cmd_op);
                    end
                end
            end
            S_DONE: begin
                state_d     = S_IDLE;
                rsp_valid_d = 1'b1;
            end
            default: begin
                if (div_q == DIV_W'(CLKDIV - 1)) begin
                    div_d = '0;
                    tck_d = ~tck_q;
                    if (!tck_q && state_q == S_SHIFT) begin
                        rsp_tdo_d[cnt_q[IDX_W-1:0]] = TDO;
                    end
                    // A falling TCK closes one period; choose what the next one drives.
                    if (tck_q) begin
                        new_period = 1'b1;
                        cnt_d      = cnt_q + LEN_W'(1);
                        case (state_q)
                            S_TLR: if (cnt_q == LEN_W'(5)) begin
                                synced_d = 1'b1;
                                cnt_d    = '0;
                                state_d  = (op_q == OP_RESET) ? S_DONE : first_state(op_q);
                            end
                            S_PRE: if (cnt_q == ((op_q == OP_IR) ? LEN_W'(3) : LEN_W'(2))) begin
                                cnt_d   = '0;
                                state_d = S_SHIFT;
                            end
                            S_SHIFT: if (cnt_q == n_q - LEN_W'(1)) begin
                                cnt_d   = '0;
                                state_d = S_POST;
                            end
                            S_POST: if (cnt_q == LEN_W'(1)) state_d = S_DONE;
                            S_RUN:  if (cnt_q == n_q - LEN_W'(1)) state_d = S_DONE;
                            default: ;
                        endcase
                    end
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
        endcase

        // TMS/TDI only move at command start or on a falling TCK, so they are stable while TCK is high.
        if (new_period) begin
            case (state_d)
                S_TLR:   tms_d = (cnt_d != LEN_W'(5));
                S_PRE:   tms_d = (op_d == OP_IR) ? (cnt_d < LEN_W'(2)) : (cnt_d == '0);
                S_SHIFT: tms_d = (cnt_d == n_d - LEN_W'(1));
                S_POST:  tms_d = (cnt_d == '0);
                S_RUN:   tms_d = 1'b0;
                default: ;
            endcase
            tdo_pin_d = (state_d == S_SHIFT) ? tdi_d[cnt_d[IDX_W-1:0]] : 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            n_q         <= '0;
            op_q        <= OP_RESET;
            tdi_q       <= '0;
            rsp_tdo_q   <= '0;
            div_q       <= '0;
            tck_q       <= 1'b0;
            tms_q       <= 1'b1;
            tdo_pin_q   <= 1'b0;
            synced_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            n_q         <= n_d;
            op_q        <= op_d;
            tdi_q       <= tdi_d;
            rsp_tdo_q   <= rsp_tdo_d;
            div_q       <= div_d;
            tck_q       <= tck_d;
            tms_q       <= tms_d;
            tdo_pin_q   <= tdo_pin_d;
            synced_q    <= synced_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

`ifdef JTAG_TDO_CMP_EN
    logic [DATA_W-1:0] exp_q, exp_d, mask_q, mask_d;
    logic              mism_q, mism_d;

    always_comb begin
        exp_d  = exp_q;
        mask_d = mask_q;
        mism_d = mism_q;
        if (accept) begin
            exp_d  = bus.cmd_exp;
            mask_d = bus.cmd_mask;
            mism_d = 1'b0;
        end
        if (rsp_valid_d) begin
            mism_d = ((op_d == OP_IR) || (op_d == OP_DR)) && (|((rsp_tdo_d ^ exp_d) & mask_d));
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            exp_q  <= '0;
            mask_q <= '0;
            mism_q <= 1'b0;
        end else begin
            exp_q  <= exp_d;
            mask_q <= mask_d;
            mism_q <= mism_d;
        end
    end

    assign bus.rsp_mismatch = mism_q;
`endif

    assign bus.cmd_ready = (state_q == S_IDLE);
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_tdo   = rsp_tdo_q;
    assign TCK           = tck_q;
    assign TMS           = tms_q;
    assign TDI           = tdo_pin_q;
endmodule

// File: tb/tb_jtag_tap_sequencer.sv
// tb/tb_jtag_tap_sequencer.sv - self-checking bench for jtag_tap_sequencer with a behavioural target TAP
module tb_jtag_tap_sequencer;
    localparam int CLKDIV = 4;
    localparam int DATA_W = 32;
    localparam int LEN_W  = 6;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic tck, tms, tdi;
    logic tdo = 1'b0;

    jtag_tap_sequencer_if #(.DATA_W(DATA_W), .LEN_W(LEN_W)) bus ();

    jtag_tap_sequencer #(.CLKDIV(CLKDIV), .DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
        .clk(clk), .reset(reset), .bus(bus),
        .TCK(tck), .TMS(tms), .TDI(tdi), .TDO(tdo)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Target TAP: standard 16-state controller, 8-bit IR (0xFF = BYPASS), 32-bit DR.
    int nxt0 [16] = '{1, 1, 3, 4, 4, 6, 6, 4, 1, 10, 11, 11, 13, 13, 11, 1};
    int nxt1 [16] = '{0, 2, 9, 5, 5, 8, 7, 8, 2, 0, 12, 12, 15, 14, 15, 2};
    int          tap_st = 0;
    logic [7:0]  ir = 8'hFF, ir_sr = 8'h00;
    logic [31:0] dr_sr = 32'h0, dr_cap = 32'h0;

    always @(posedge tck) begin
        case (tap_st)
            0:  ir = 8'hFF;
            3:  dr_sr = (ir == 8'hFF) ? 32'h0 : dr_cap;
            4:  if (ir == 8'hFF) dr_sr = {31'h0, tdi}; else dr_sr = {tdi, dr_sr[31:1]};
            10: ir_sr = 8'h01;
            11: ir_sr = {tdi, ir_sr[7:1]};
            15: ir = ir_sr;
            default: ;
        endcase
        tap_st = tms ? nxt1[tap_st] : nxt0[tap_st];
    end

    always @(negedge tck) tdo = (tap_st == 11) ? ir_sr[0] : (tap_st == 4) ? dr_sr[0] : 1'b0;

    // Pin monitor, sampled 1 time unit after each rising clk.
    int unsigned cyc = 0;
    always @(posedge clk) cyc++;
    bit   obs_tms[$], obs_tdi[$];
    int   rise_cnt = 0, edge_viol = 0;
    int unsigned last_fall = 0;
    logic p_tck = 1'b0, p_tms = 1'b1, p_tdi = 1'b0;
    always begin
        @(posedge clk);
        #1;
        if (tck === 1'b1 && (tms !== p_tms || tdi !== p_tdi)) edge_viol++;
        if (tck === 1'b1 && p_tck === 1'b0) begin
            obs_tms.push_back(tms);
            obs_tdi.push_back(tdi);
            rise_cnt++;
        end
        if (tck === 1'b0 && p_tck === 1'b1) last_fall = cyc;
        p_tck = tck; p_tms = tms; p_tdi = tdi;
    end

    // Host-side view of the TAP, derived from the command rules.
    bit         synced_exp = 1'b0;
    logic [7:0] ir_exp = 8'hFF;
    bit         exp_tms[$], exp_tdi[$];

    task automatic push_clk(input bit m, input bit d);
        exp_tms.push_back(m);
        exp_tdi.push_back(d);
    endtask

    task automatic run_cmd(input string tag, input logic [1:0] op, input int len, input logic [31:0] tdi_v,
                           input logic [31:0] exp_v, input logic [31:0] mask_v, output logic [31:0] rsp);
        int n, w, seq_err;
        bit is_sh, got;
        logic [31:0] cap, exp_rsp;
        logic exp_mis;
        is_sh   = (op == 2'b01) || (op == 2'b10);
        n       = (is_sh && len > DATA_W) ? DATA_W : len;
        exp_rsp = '0;
        exp_tms.delete();
        exp_tdi.delete();
        if (op == 2'b00 || n > 0) begin
            if (!synced_exp || op == 2'b00) begin
                for (int i = 0; i < 6; i++) push_clk(i < 5, 1'b0);
                ir_exp     = 8'hFF;
                synced_exp = 1'b1;
            end
            if (op == 2'b01) begin push_clk(1, 0); push_clk(1, 0); push_clk(0, 0); push_clk(0, 0); end
            if (op == 2'b10) begin push_clk(1, 0); push_clk(0, 0); push_clk(0, 0); end
            if (is_sh) begin
                for (int i = 0; i < n; i++) push_clk(i == n - 1, tdi_v[i]);
                push_clk(1, 0);
                push_clk(0, 0);
            end
            if (op == 2'b11) for (int i = 0; i < n; i++) push_clk(0, 0);
        end
        if (op == 2'b01)          begin w = 8;  cap = 32'h1; end
        else if (ir_exp == 8'hFF) begin w = 1;  cap = 32'h0; end
        else                      begin w = 32; cap = dr_cap; end
        if (is_sh) for (int i = 0; i < n; i++) exp_rsp[i] = (i < w) ? cap[i] : tdi_v[i - w];
        if (op == 2'b01 && n > 0) for (int j = 0; j < 8; j++) ir_exp[j] = (j + n < 8) ? cap[j + n] : tdi_v[j + n - 8];
        exp_mis = is_sh && (|((exp_rsp ^ exp_v) & mask_v));

        @(negedge clk);
        rise_cnt = 0;
        edge_viol = 0;
        obs_tms.delete();
        obs_tdi.delete();
        check($sformatf("%s_ready_before", tag), bus.cmd_ready, 1);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_len   = LEN_W'(len);
        bus.cmd_tdi   = tdi_v;
`ifdef JTAG_TDO_CMP_EN
        bus.cmd_exp   = exp_v;
        bus.cmd_mask  = mask_v;
`endif
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 2'($urandom);
        bus.cmd_len   = LEN_W'($urandom);
        bus.cmd_tdi   = $urandom;
        if (op != 2'b00 && n == 0) begin
            check($sformatf("%s_zero_len_rsp_next_cycle", tag), bus.rsp_valid, 1);
        end else begin
            check($sformatf("%s_busy_after_accept", tag), bus.busy, 1);
        end
        got = 1'b0;
        for (int k = 0; k < 3000 && !got; k++) begin
            if (bus.rsp_valid === 1'b1) got = 1'b1;
            else @(negedge clk);
        end
        check($sformatf("%s_rsp_seen", tag), got, 1);
        rsp = bus.rsp_tdo;
        if (got) begin
            if (exp_tms.size() > 0) check($sformatf("%s_fall_to_rsp_cycles", tag), 64'(cyc - last_fall), 1);
            check($sformatf("%s_ready_with_rsp", tag), bus.cmd_ready, 1);
            check($sformatf("%s_rsp_tdo", tag), bus.rsp_tdo, exp_rsp);
`ifdef JTAG_TDO_CMP_EN
            check($sformatf("%s_mismatch", tag), bus.rsp_mismatch, exp_mis);
`endif
            @(negedge clk);
            check($sformatf("%s_rsp_pulse_one_cycle", tag), bus.rsp_valid, 0);
            check($sformatf("%s_rsp_tdo_held", tag), bus.rsp_tdo, exp_rsp);
        end
        check($sformatf("%s_tck_count", tag), rise_cnt, exp_tms.size());
        seq_err = (obs_tms.size() > exp_tms.size()) ? obs_tms.size() - exp_tms.size() : exp_tms.size() - obs_tms.size();
        for (int i = 0; i < obs_tms.size() && i < exp_tms.size(); i++) begin
            if (obs_tms[i] != exp_tms[i]) seq_err++;
            if (obs_tdi[i] != exp_tdi[i]) seq_err++;
        end
        check($sformatf("%s_tms_tdi_sequence_errors", tag), seq_err, 0);
        check($sformatf("%s_edge_rule_violations", tag), edge_viol, 0);
        if (exp_tms.size() > 0) check($sformatf("%s_target_in_rti", tag), tap_st, 1);
    endtask

    logic [31:0] r;

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 2'b00;
        bus.cmd_len   = '0;
        bus.cmd_tdi   = '0;
`ifdef JTAG_TDO_CMP_EN
        bus.cmd_exp   = '0;
        bus.cmd_mask  = '0;
`endif
        #1 reset = 1'b1;
        #1;
        check("reset_tck", tck, 0);
        check("reset_tms", tms, 1);
        check("reset_tdi", tdi, 0);
        check("reset_cmd_ready", bus.cmd_ready, 1);
        check("reset_rsp_valid", bus.rsp_valid, 0);
        check("reset_rsp_tdo", bus.rsp_tdo, 0);
        check("reset_busy", bus.busy, 0);
`ifdef JTAG_TDO_CMP_EN
        check("reset_mismatch", bus.rsp_mismatch, 0);
`endif
        repeat (3) @(negedge clk);
        reset = 1'b0;

        run_cmd("ir_a5", 2'b01, 8, 32'hA5, 0, 0, r);
        check("ir_a5_literal", r, 32'h01);
        check("target_ir_a5", ir, 8'hA5);
        run_cmd("ir_bypass", 2'b01, 8, 32'hFF, 0, 0, r);
        run_cmd("dr_bypass_32", 2'b10, 32, 32'hDEADBEEF, 0, 0, r);
        check("dr_bypass_literal", r, 32'hBD5B7DDE);
        run_cmd("idle_10", 2'b11, 10, 32'h0, 0, 0, r);
        run_cmd("idle_0", 2'b11, 0, 32'h0, 0, 0, r);
        run_cmd("dr_len0", 2'b10, 0, 32'hFFFF_FFFF, 0, 0, r);
        run_cmd("dr_clamp_40", 2'b10, 40, 32'h1234_5678, 0, 0, r);

        run_cmd("ir_02", 2'b01, 8, 32'h02, 0, 0, r);
        dr_cap = 32'hA3;
        run_cmd("cmp_match", 2'b10, 8, 32'h0F, 32'hA5, 32'hF0, r);
        check("cmp_match_literal", r, 32'hA3);
        dr_cap = 32'h55;
        run_cmd("cmp_miss", 2'b10, 8, 32'h0F, 32'hA5, 32'hF0, r);
        check("cmp_miss_literal", r, 32'h55);
        run_cmd("idle_cmp", 2'b11, 3, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, r);

        for (int it = 0; it < 8; it++) begin
            logic [1:0] op;
            int len;
            op = 2'($urandom_range(0, 3));
            dr_cap = $urandom;
            case (op)
                2'b01:   len = $urandom_range(1, 16);
                2'b10:   len = $urandom_range(0, 40);
                2'b11:   len = $urandom_range(0, 12);
                default: len = 0;
            endcase
            run_cmd($sformatf("rand%0d_op%0d_len%0d", it, op, len), op, len, $urandom, $urandom, $urandom, r);
        end

        // Reset in the middle of a DR shift, then resync on the next command.
        @(negedge clk);
        rise_cnt = 0;
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 2'b10;
        bus.cmd_len   = LEN_W'(32);
        bus.cmd_tdi   = $urandom;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        for (int k = 0; k < 1000 && rise_cnt < 9; k++) @(negedge clk);
        check("midreset_reached_bit5", rise_cnt, 9);
        #1 reset = 1'b1;
        #1;
        check("midreset_tck", tck, 0);
        check("midreset_tms", tms, 1);
        check("midreset_tdi", tdi, 0);
        check("midreset_ready", bus.cmd_ready, 1);
        check("midreset_rsp_valid", bus.rsp_valid, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        synced_exp = 1'b0;
        repeat (2) @(negedge clk);
        check("midreset_no_rsp", bus.rsp_valid, 0);
        run_cmd("dr4_after_reset", 2'b10, 4, 32'h9, 0, 0, r);
        run_cmd("tap_reset_synced", 2'b00, 0, 32'h0, 0, 0, r);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
